// File: rtl/cv32e40p_debug_req_ctrl.sv
// cv32e40p_debug_req_ctrl
// Arbitrates halt requests from N_REQ debug requesters onto the single core
// debug request line and sequences each halt / resume handshake, with
// per-phase timeouts so a silent core can never lock the arbiter.
//
// Build option: define DBG_REQ_FIXED_PRIO_EN to replace the round-robin
// arbiter by a fixed-priority one (lowest index wins, no RR pointer).
// Ports and cycle timing are identical in both builds.

module cv32e40p_debug_req_ctrl #(
  parameter int N_REQ          = 2,
  parameter int HALT_TIMEOUT   = 64,
  parameter int RESUME_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             debug_havereset_o,
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [N_REQ-1:0] release_i,
  output logic [N_REQ-1:0] req_ack_o,
  output logic [N_REQ-1:0] owner_o,
  output logic             debug_req_o,
  input  logic             debug_halted_i,
  input  logic             debug_running_i,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam int MAX_TO = (HALT_TIMEOUT > RESUME_TIMEOUT) ? HALT_TIMEOUT : RESUME_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_TO + 1);

  localparam logic [CNT_W-1:0] HALT_LAST   = CNT_W'(HALT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RESUME_LAST = CNT_W'(RESUME_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_TO);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2,
    ST_RESUME = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] req_ack_q, req_ack_d;
  logic             debug_req_q, debug_req_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] grant_oh_s;
  logic             any_req_s;
  logic             owner_release_s;
  logic             halt_to_s;
  logic             resume_to_s;

  assign any_req_s       = |req_valid_i;
  assign owner_release_s = |(release_i & owner_q);

`ifdef DBG_REQ_FIXED_PRIO_EN

  // Fixed-priority grant: the lowest-index active requester wins.
  always_comb begin
    logic found;
    grant_oh_s = '0;
    found      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid_i[i]) begin
        grant_oh_s[i] = 1'b1;
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
  end

`else

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] grant_idx_s;

  // Round-robin grant: scan requesters starting at the RR pointer.
  always_comb begin
    logic found;
    int   idx;
    grant_oh_s  = '0;
    grant_idx_s = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found && req_valid_i[IDX_W'(idx)]) begin
        grant_oh_s[IDX_W'(idx)] = 1'b1;
        grant_idx_s             = IDX_W'(idx);
        found                   = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // RR pointer moves past the winner only when a grant is actually issued.
  always_comb begin
    rr_d = rr_q;
    if ((state_q == ST_IDLE) && any_req_s) begin
      if (grant_idx_s == IDX_W'(N_REQ - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = grant_idx_s + IDX_W'(1);
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // RR pointer register.
  always_ff @(posedge clk_i or negedge debug_havereset_o) begin
    if (!debug_havereset_o) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

`endif

  // State, counter and registered-output flops; reset aborts any phase at once.
  always_ff @(posedge clk_i or negedge debug_havereset_o) begin
    if (!debug_havereset_o) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= '0;
      req_ack_q   <= '0;
      debug_req_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      req_ack_q   <= req_ack_d;
      debug_req_q <= debug_req_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; core responses take precedence over a coincident timeout.
  always_comb begin
    state_d     = state_q;
    halt_to_s   = 1'b0;
    resume_to_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (debug_halted_i) begin
          state_d = ST_HALTED;
        end else if (cnt_q == HALT_LAST) begin
          state_d   = ST_IDLE;
          halt_to_s = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HALTED: begin
        if (owner_release_s) begin
          state_d = ST_RESUME;
        end else if (debug_running_i && !debug_halted_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RESUME: begin
        if (debug_running_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == RESUME_LAST) begin
          state_d     = ST_IDLE;
          resume_to_s = 1'b1;
        end else begin
          state_d = ST_RESUME;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the phase counter and all registered outputs.
  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    req_ack_d   = '0;
    debug_req_d = (state_d == ST_REQ);
    busy_d      = (state_d != ST_IDLE);
    timeout_d   = halt_to_s | resume_to_s;

    // Counter restarts on every state entry and saturates instead of wrapping.
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_d == ST_IDLE) begin
      owner_d = '0;
    end else if (state_q == ST_IDLE) begin
      owner_d = grant_oh_s;
    end else begin
      owner_d = owner_q;
    end

    if ((state_q == ST_REQ) && (state_d == ST_HALTED)) begin
      req_ack_d = owner_q;
    end else begin
      req_ack_d = '0;
    end
  end

  assign owner_o     = owner_q;
  assign req_ack_o   = req_ack_q;
  assign debug_req_o = debug_req_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy_q;

endmodule
